// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron_seq MAC sequencer.
package neuron_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUT
    } state_e;

    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned STALL_W      = 16;

endpackage

// File: rtl/ReLU_Nbits.sv
// Combinational rectify/truncate: zero for a negative 2N-bit sum, else its upper N bits.
module ReLU_Nbits #(
    parameter int unsigned N = 18
) (
    input  logic [2*N-1:0] din,
    output logic [N-1:0]   dout
);

    assign dout = din[2*N-1] ? '0 : din[2*N-1:N];

endmodule

// File: rtl/mac_Nbits.sv
// Signed N x N multiply-accumulate into a 2N-bit register with synchronous clear.
module mac_Nbits #(
    parameter int unsigned N = 18
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [N-1:0]   w,
    input  logic [N-1:0]   x,
    output logic [2*N-1:0] acc
);

    logic signed [2*N-1:0] w_ext;
    logic signed [2*N-1:0] x_ext;
    logic signed [2*N-1:0] prod;
    logic        [2*N-1:0] acc_q;
    logic        [2*N-1:0] acc_d;

    assign w_ext = {{N{w[N-1]}}, w};
    assign x_ext = {{N{x[N-1]}}, x};
    assign prod  = w_ext * x_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/neuron_seq.sv
// Drives an external MAC through one dot product and returns ReLU of the upper half.
// Optional FEED stall counter output enabled by defining NEURON_STALL_CNT_EN.
module neuron_seq
    import neuron_pkg::*;
#(
    parameter int unsigned N     = 18,
    parameter int unsigned K_MAX = 64,
    parameter int unsigned CW    = $clog2(K_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CW-1:0]      cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_w,
    input  logic [N-1:0]       in_x,
    output logic [N-1:0]       mac_w,
    output logic [N-1:0]       mac_x,
    output logic               mac_en,
    output logic               mac_clr,
    input  logic [2*N-1:0]     mac_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
`ifdef NEURON_STALL_CNT_EN
    output logic [STALL_W-1:0] stall_cnt,
`endif
    output logic               busy
);

    state_e        state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          drain_q, drain_d;
    logic          in_ready_q, in_ready_d;
    logic [N-1:0]  mac_w_q, mac_w_d;
    logic [N-1:0]  mac_x_q, mac_x_d;
    logic          mac_en_q, mac_en_d;
    logic          mac_clr_q, mac_clr_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  relu_out;
    logic          hs;

    ReLU_Nbits #(
        .N(N)
    ) u_relu (
        .din (mac_acc),
        .dout(relu_out)
    );

    assign hs      = (state_q == S_FEED) && in_valid && in_ready_q;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        in_ready_d  = 1'b0;
        mac_w_d     = mac_w_q;
        mac_x_d     = mac_x_q;
        mac_en_d    = 1'b0;
        mac_clr_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = (cfg_len > CW'(K_MAX)) ? CW'(K_MAX) : cfg_len;
                    cnt_d     = '0;
                    mac_clr_d = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                drain_d = 1'b0;
                if (len_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = S_FEED;
                end
            end
            S_FEED: begin
                in_ready_d = in_ready_q;
                if (hs) begin
                    mac_w_d  = in_w;
                    mac_x_d  = in_x;
                    mac_en_d = 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_q) begin
                        in_ready_d = 1'b0;
                        drain_d    = 1'b0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Second cycle: the last accumulate has settled on mac_acc.
                if (drain_q == 1'(DRAIN_CYCLES - 1)) begin
                    out_data_d  = relu_out;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            mac_w_q     <= '0;
            mac_x_q     <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            in_ready_q  <= in_ready_d;
            mac_w_q     <= mac_w_d;
            mac_x_q     <= mac_x_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

`ifdef NEURON_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == S_FEED) && in_ready_q && !in_valid && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign in_ready  = in_ready_q;
    assign mac_w     = mac_w_q;
    assign mac_x     = mac_x_q;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
